// File: rtl/int_register_read_stage_if.sv
// Bundle of issue, register-file, writeback, control and execute-side signals for the
// integer register-read stage; master is the surrounding pipeline, slave is the stage.
interface int_register_read_stage_if #(
    parameter int ISSUE_WIDTH = 2,
    parameter int WB_WIDTH    = 2,
    parameter int PREG_W      = 7,
    parameter int DATA_W      = 32,
    parameter int AL_PTR_W    = 6,
    parameter int PAYLOAD_W   = 48
);
    logic                             stall;
    logic                             clear;

    logic [ISSUE_WIDTH-1:0]           in_valid;
    logic [ISSUE_WIDTH*PREG_W-1:0]    in_src_a;
    logic [ISSUE_WIDTH*PREG_W-1:0]    in_src_b;
    logic [ISSUE_WIDTH*PREG_W-1:0]    in_dst;
    logic [ISSUE_WIDTH*AL_PTR_W-1:0]  in_al_ptr;
    logic [ISSUE_WIDTH*PAYLOAD_W-1:0] in_payload;

    logic [2*ISSUE_WIDTH*PREG_W-1:0]  rf_raddr;
    logic [2*ISSUE_WIDTH*DATA_W-1:0]  rf_rdata;

    logic [WB_WIDTH-1:0]              wb_valid;
    logic [WB_WIDTH*PREG_W-1:0]       wb_dst;
    logic [WB_WIDTH*DATA_W-1:0]       wb_data;

    logic                             flush_req;
    logic                             flush_all;
    logic [AL_PTR_W-1:0]              flush_head;
    logic [AL_PTR_W-1:0]              flush_tail;

    logic [ISSUE_WIDTH-1:0]           out_valid;
    logic [ISSUE_WIDTH*DATA_W-1:0]    out_op_a;
    logic [ISSUE_WIDTH*DATA_W-1:0]    out_op_b;
    logic [ISSUE_WIDTH*PREG_W-1:0]    out_dst;
    logic [ISSUE_WIDTH*AL_PTR_W-1:0]  out_al_ptr;
    logic [ISSUE_WIDTH*PAYLOAD_W-1:0] out_payload;

    modport master (
        output stall, clear,
        output in_valid, in_src_a, in_src_b, in_dst, in_al_ptr, in_payload,
        input  rf_raddr,
        output rf_rdata,
        output wb_valid, wb_dst, wb_data,
        output flush_req, flush_all, flush_head, flush_tail,
        input  out_valid, out_op_a, out_op_b, out_dst, out_al_ptr, out_payload
    );

    modport slave (
        input  stall, clear,
        input  in_valid, in_src_a, in_src_b, in_dst, in_al_ptr, in_payload,
        output rf_raddr,
        input  rf_rdata,
        input  wb_valid, wb_dst, wb_data,
        input  flush_req, flush_all, flush_head, flush_tail,
        output out_valid, out_op_a, out_op_b, out_dst, out_al_ptr, out_payload
    );
endinterface

// File: rtl/int_register_read_stage.sv
// Integer register-read stage: stage register S, RF read + optional writeback bypass, output register O.
// Define RSD_INT_RR_BYPASS_EN to enable the writeback bypass network; otherwise operands come from the RF only.
module int_register_read_stage #(
    parameter int ISSUE_WIDTH = 2,
    parameter int WB_WIDTH    = 2,
    parameter int PREG_W      = 7,
    parameter int DATA_W      = 32,
    parameter int AL_PTR_W    = 6,
    parameter int PAYLOAD_W   = 48
) (
    input logic clk,
    input logic rst,
    int_register_read_stage_if.slave rr_if
);

    localparam int OPW = ISSUE_WIDTH * DATA_W;
    localparam int RW  = ISSUE_WIDTH * PREG_W;
    localparam int AW  = ISSUE_WIDTH * AL_PTR_W;
    localparam int PW  = ISSUE_WIDTH * PAYLOAD_W;

    logic [ISSUE_WIDTH-1:0] s_valid_q, s_valid_d;
    logic [RW-1:0]          s_src_a_q, s_src_a_d;
    logic [RW-1:0]          s_src_b_q, s_src_b_d;
    logic [RW-1:0]          s_dst_q,   s_dst_d;
    logic [AW-1:0]          s_al_q,    s_al_d;
    logic [PW-1:0]          s_pl_q,    s_pl_d;

    logic [ISSUE_WIDTH-1:0] o_valid_q, o_valid_d;
    logic [OPW-1:0]         o_op_a_q,  o_op_a_d;
    logic [OPW-1:0]         o_op_b_q,  o_op_b_d;
    logic [RW-1:0]          o_dst_q,   o_dst_d;
    logic [AW-1:0]          o_al_q,    o_al_d;
    logic [PW-1:0]          o_pl_q,    o_pl_d;

    logic [OPW-1:0]         h_op_a_q,  h_op_a_d;
    logic [OPW-1:0]         h_op_b_q,  h_op_b_d;
    logic                   held_q,    held_d;

    logic [OPW-1:0]         res_a, res_b;
    logic [OPW-1:0]         eff_a, eff_b;

    // Range is [head, tail) modulo the pointer width; head == tail means nothing is in range.
    function automatic logic flush_hit(
        input logic [AL_PTR_W-1:0] p,
        input logic                req,
        input logic                all,
        input logic [AL_PTR_W-1:0] head,
        input logic [AL_PTR_W-1:0] tail
    );
        logic in_range;
        if (head < tail)
            in_range = (p >= head) && (p < tail);
        else if (head > tail)
            in_range = (p >= head) || (p < tail);
        else
            in_range = 1'b0;
        return req && (all || in_range);
    endfunction

    always_comb begin
        rr_if.rf_raddr = '0;
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            rr_if.rf_raddr[(2*i)*PREG_W   +: PREG_W] = s_src_a_q[i*PREG_W +: PREG_W];
            rr_if.rf_raddr[(2*i+1)*PREG_W +: PREG_W] = s_src_b_q[i*PREG_W +: PREG_W];
        end
    end

    // Later writeback lanes override earlier ones, so the highest matching lane wins.
    always_comb begin
        res_a = '0;
        res_b = '0;
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            res_a[i*DATA_W +: DATA_W] = rr_if.rf_rdata[(2*i)*DATA_W   +: DATA_W];
            res_b[i*DATA_W +: DATA_W] = rr_if.rf_rdata[(2*i+1)*DATA_W +: DATA_W];
`ifdef RSD_INT_RR_BYPASS_EN
            for (int j = 0; j < WB_WIDTH; j++) begin
                if (rr_if.wb_valid[j] && (rr_if.wb_dst[j*PREG_W +: PREG_W] == s_src_a_q[i*PREG_W +: PREG_W]))
                    res_a[i*DATA_W +: DATA_W] = rr_if.wb_data[j*DATA_W +: DATA_W];
                if (rr_if.wb_valid[j] && (rr_if.wb_dst[j*PREG_W +: PREG_W] == s_src_b_q[i*PREG_W +: PREG_W]))
                    res_b[i*DATA_W +: DATA_W] = rr_if.wb_data[j*DATA_W +: DATA_W];
            end
`endif
        end
    end

`ifndef RSD_INT_RR_BYPASS_EN
    logic wb_unused;
    assign wb_unused = ^{rr_if.wb_valid, rr_if.wb_dst, rr_if.wb_data};
`endif

    assign eff_a = held_q ? h_op_a_q : res_a;
    assign eff_b = held_q ? h_op_b_q : res_b;

    // During a stall the fields freeze, but the first-cycle operands are latched into H so that
    // RF contents changing underneath the stalled op cannot leak into execute on release.
    always_comb begin
        s_valid_d = s_valid_q;
        s_src_a_d = s_src_a_q;
        s_src_b_d = s_src_b_q;
        s_dst_d   = s_dst_q;
        s_al_d    = s_al_q;
        s_pl_d    = s_pl_q;
        o_valid_d = o_valid_q;
        o_op_a_d  = o_op_a_q;
        o_op_b_d  = o_op_b_q;
        o_dst_d   = o_dst_q;
        o_al_d    = o_al_q;
        o_pl_d    = o_pl_q;
        h_op_a_d  = h_op_a_q;
        h_op_b_d  = h_op_b_q;
        held_d    = held_q;

        if (!rr_if.stall) begin
            s_src_a_d = rr_if.in_src_a;
            s_src_b_d = rr_if.in_src_b;
            s_dst_d   = rr_if.in_dst;
            s_al_d    = rr_if.in_al_ptr;
            s_pl_d    = rr_if.in_payload;
            o_op_a_d  = eff_a;
            o_op_b_d  = eff_b;
            o_dst_d   = s_dst_q;
            o_al_d    = s_al_q;
            o_pl_d    = s_pl_q;
            held_d    = 1'b0;
            for (int i = 0; i < ISSUE_WIDTH; i++) begin
                s_valid_d[i] = rr_if.in_valid[i] && !rr_if.clear &&
                               !flush_hit(rr_if.in_al_ptr[i*AL_PTR_W +: AL_PTR_W], rr_if.flush_req,
                                          rr_if.flush_all, rr_if.flush_head, rr_if.flush_tail);
                o_valid_d[i] = s_valid_q[i] && !rr_if.clear &&
                               !flush_hit(s_al_q[i*AL_PTR_W +: AL_PTR_W], rr_if.flush_req,
                                          rr_if.flush_all, rr_if.flush_head, rr_if.flush_tail);
            end
        end else begin
            if (!held_q) begin
                h_op_a_d = res_a;
                h_op_b_d = res_b;
                held_d   = 1'b1;
            end
            for (int i = 0; i < ISSUE_WIDTH; i++) begin
                s_valid_d[i] = s_valid_q[i] && !rr_if.clear &&
                               !flush_hit(s_al_q[i*AL_PTR_W +: AL_PTR_W], rr_if.flush_req,
                                          rr_if.flush_all, rr_if.flush_head, rr_if.flush_tail);
                o_valid_d[i] = o_valid_q[i] && !rr_if.clear &&
                               !flush_hit(o_al_q[i*AL_PTR_W +: AL_PTR_W], rr_if.flush_req,
                                          rr_if.flush_all, rr_if.flush_head, rr_if.flush_tail);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_valid_q <= '0;
            s_src_a_q <= '0;
            s_src_b_q <= '0;
            s_dst_q   <= '0;
            s_al_q    <= '0;
            s_pl_q    <= '0;
            o_valid_q <= '0;
            o_op_a_q  <= '0;
            o_op_b_q  <= '0;
            o_dst_q   <= '0;
            o_al_q    <= '0;
            o_pl_q    <= '0;
            h_op_a_q  <= '0;
            h_op_b_q  <= '0;
            held_q    <= 1'b0;
        end else begin
            s_valid_q <= s_valid_d;
            s_src_a_q <= s_src_a_d;
            s_src_b_q <= s_src_b_d;
            s_dst_q   <= s_dst_d;
            s_al_q    <= s_al_d;
            s_pl_q    <= s_pl_d;
            o_valid_q <= o_valid_d;
            o_op_a_q  <= o_op_a_d;
            o_op_b_q  <= o_op_b_d;
            o_dst_q   <= o_dst_d;
            o_al_q    <= o_al_d;
            o_pl_q    <= o_pl_d;
            h_op_a_q  <= h_op_a_d;
            h_op_b_q  <= h_op_b_d;
            held_q    <= held_d;
        end
    end

    assign rr_if.out_valid   = o_valid_q;
    assign rr_if.out_op_a    = o_op_a_q;
    assign rr_if.out_op_b    = o_op_b_q;
    assign rr_if.out_dst     = o_dst_q;
    assign rr_if.out_al_ptr  = o_al_q;
    assign rr_if.out_payload = o_pl_q;

endmodule

// File: tb/tb_int_register_read_stage.sv
// Directed bench for int_register_read_stage: latency, bypass, stall hold, wrapping flush,
// clear/flush_all under stall, back-to-back streaming and asynchronous reset.
module tb_int_register_read_stage;

    localparam int IW = 2;
    localparam int WB = 2;
    localparam int PR = 7;
    localparam int DW = 32;
    localparam int AW = 6;
    localparam int LW = 48;

    logic clk = 1'b0;
    logic rst;
    logic rfOverride;
    logic [DW-1:0] rfOverrideVal;
    int compareCount = 0;
    int failCount = 0;

    always #5 clk = ~clk;

    int_register_read_stage_if #(
        .ISSUE_WIDTH(IW), .WB_WIDTH(WB), .PREG_W(PR),
        .DATA_W(DW), .AL_PTR_W(AW), .PAYLOAD_W(LW)
    ) rrIf ();

    int_register_read_stage #(
        .ISSUE_WIDTH(IW), .WB_WIDTH(WB), .PREG_W(PR),
        .DATA_W(DW), .AL_PTR_W(AW), .PAYLOAD_W(LW)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .rr_if(rrIf)
    );

    // Register file model: each register reads as C0DE0000 | index unless overridden.
    function automatic logic [DW-1:0] rfVal(input int addr);
        return 32'hC0DE0000 | 32'(addr);
    endfunction

    for (genvar k = 0; k < 2*IW; k++) begin : g_rf
        assign rrIf.rf_rdata[k*DW +: DW] = rfOverride ? rfOverrideVal
                                         : (32'hC0DE0000 | {25'b0, rrIf.rf_raddr[k*PR +: PR]});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int lane, input logic v, input int srcA, input int srcB,
                                 input int dst, input int al, input logic [LW-1:0] pl);
        rrIf.in_valid[lane]              = v;
        rrIf.in_src_a[lane*PR +: PR]     = PR'(srcA);
        rrIf.in_src_b[lane*PR +: PR]     = PR'(srcB);
        rrIf.in_dst[lane*PR +: PR]       = PR'(dst);
        rrIf.in_al_ptr[lane*AW +: AW]    = AW'(al);
        rrIf.in_payload[lane*LW +: LW]   = pl;
    endtask

    task automatic clearLanes();
        for (int l = 0; l < IW; l++) applyStimulus(l, 1'b0, 0, 0, 0, 0, '0);
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        compareCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        rst = 1'b1;
        rfOverride = 1'b0;
        rfOverrideVal = '0;
        rrIf.stall = 1'b0;
        rrIf.clear = 1'b0;
        rrIf.wb_valid = '0;
        rrIf.wb_dst = '0;
        rrIf.wb_data = '0;
        rrIf.flush_req = 1'b0;
        rrIf.flush_all = 1'b0;
        rrIf.flush_head = '0;
        rrIf.flush_tail = '0;
        clearLanes();

        #12;
        checkOutput("rst_valid",   128'(rrIf.out_valid),   128'(0));
        checkOutput("rst_op_a",    128'(rrIf.out_op_a),    128'(0));
        checkOutput("rst_payload", 128'(rrIf.out_payload), 128'(0));
        rst = 1'b0;
        tick();

        // Basic two-lane op: one edge into S, second edge into O.
        applyStimulus(0, 1'b1, 10, 20, 30, 4, 48'h123);
        applyStimulus(1, 1'b1, 11, 21, 31, 5, 48'h456);
        tick();
        clearLanes();
        checkOutput("latency_valid", 128'(rrIf.out_valid), 128'(0));
        tick();
        checkOutput("basic_valid",   128'(rrIf.out_valid), 128'(2'b11));
        checkOutput("basic_op_a0",   128'(rrIf.out_op_a[31:0]),  128'(rfVal(10)));
        checkOutput("basic_op_b1",   128'(rrIf.out_op_b[63:32]), 128'(rfVal(21)));
        checkOutput("basic_payload", 128'(rrIf.out_payload), 128'({48'h456, 48'h123}));
        checkOutput("basic_dst_al",  128'({rrIf.out_dst, rrIf.out_al_ptr}),
                                     128'({7'd31, 7'd30, 6'd5, 6'd4}));
        tick();
        checkOutput("drain_valid", 128'(rrIf.out_valid), 128'(0));

        // Bypass: two writeback lanes hit src_a, lane 1 has priority.
        rfOverride = 1'b1;
        rfOverrideVal = 32'h11;
        rrIf.wb_valid = 2'b11;
        rrIf.wb_dst = {7'd5, 7'd5};
        rrIf.wb_data = {32'hAA, 32'hBB};
        applyStimulus(0, 1'b1, 5, 6, 40, 7, 48'hC0);
        tick();
        clearLanes();
        tick();
        checkOutput("bypass_valid", 128'(rrIf.out_valid), 128'(2'b01));
`ifdef RSD_INT_RR_BYPASS_EN
        checkOutput("bypass_op_a0", 128'(rrIf.out_op_a[31:0]), 128'(32'hAA));
`else
        checkOutput("bypass_op_a0", 128'(rrIf.out_op_a[31:0]), 128'(32'h11));
`endif
        checkOutput("bypass_op_b0", 128'(rrIf.out_op_b[31:0]), 128'(32'h11));
        rrIf.wb_valid = '0;
        rfOverride = 1'b0;
        tick();

        // Stall hold: operands captured on the first stall cycle survive an RF change.
        applyStimulus(0, 1'b1, 7, 8, 41, 9, 48'hD0);
        tick();
        clearLanes();
        rrIf.stall = 1'b1;
        tick();
        rfOverride = 1'b1;
        rfOverrideVal = 32'hDEAD;
        tick();
        tick();
        checkOutput("stall_hold_valid", 128'(rrIf.out_valid), 128'(0));
        rrIf.stall = 1'b0;
        tick();
        checkOutput("stall_rel_valid",   128'(rrIf.out_valid), 128'(2'b01));
        checkOutput("stall_rel_op_a0",   128'(rrIf.out_op_a[31:0]), 128'(rfVal(7)));
        checkOutput("stall_rel_op_b0",   128'(rrIf.out_op_b[31:0]), 128'(rfVal(8)));
        checkOutput("stall_rel_payload", 128'(rrIf.out_payload[47:0]), 128'(48'hD0));
        rfOverride = 1'b0;
        tick();

        // Wrapping flush range [60, 2): 61 and 63 flushed, 3 and 2 survive.
        applyStimulus(0, 1'b1, 1, 2, 42, 61, 48'hA61);
        applyStimulus(1, 1'b1, 3, 4, 43, 3, 48'hA03);
        tick();
        applyStimulus(0, 1'b1, 1, 2, 44, 63, 48'hB63);
        applyStimulus(1, 1'b1, 3, 4, 45, 2, 48'hB02);
        rrIf.flush_req = 1'b1;
        rrIf.flush_head = 6'd60;
        rrIf.flush_tail = 6'd2;
        tick();
        checkOutput("wrap_valid",    128'(rrIf.out_valid), 128'(2'b10));
        checkOutput("wrap_payload1", 128'(rrIf.out_payload[95:48]), 128'(48'hA03));
        rrIf.flush_req = 1'b0;
        clearLanes();
        tick();
        checkOutput("wrap_issue_valid",    128'(rrIf.out_valid), 128'(2'b10));
        checkOutput("wrap_issue_payload1", 128'(rrIf.out_payload[95:48]), 128'(48'hB02));
        tick();

        // Clear while stalled with S and O both valid.
        applyStimulus(0, 1'b1, 1, 1, 1, 10, 48'hF0);
        applyStimulus(1, 1'b1, 2, 2, 2, 11, 48'hF1);
        tick();
        applyStimulus(0, 1'b1, 3, 3, 3, 12, 48'hF2);
        applyStimulus(1, 1'b1, 4, 4, 4, 13, 48'hF3);
        tick();
        clearLanes();
        rrIf.stall = 1'b1;
        rrIf.clear = 1'b1;
        tick();
        checkOutput("clear_valid",   128'(rrIf.out_valid), 128'(0));
        checkOutput("clear_payload", 128'(rrIf.out_payload), 128'({48'hF1, 48'hF0}));
        rrIf.clear = 1'b0;
        rrIf.stall = 1'b0;
        tick();
        checkOutput("clear_rel_valid",   128'(rrIf.out_valid), 128'(0));
        checkOutput("clear_rel_payload", 128'(rrIf.out_payload), 128'({48'hF3, 48'hF2}));
        tick();

        // Empty range (head == tail) flushes nothing; flush_all under stall kills S and O.
        applyStimulus(0, 1'b1, 1, 1, 1, 5, 48'h51);
        applyStimulus(1, 1'b1, 2, 2, 2, 5, 48'h52);
        tick();
        applyStimulus(0, 1'b1, 1, 1, 1, 20, 48'h61);
        applyStimulus(1, 1'b1, 2, 2, 2, 21, 48'h62);
        rrIf.flush_req = 1'b1;
        rrIf.flush_head = 6'd5;
        rrIf.flush_tail = 6'd5;
        tick();
        checkOutput("empty_range_valid", 128'(rrIf.out_valid), 128'(2'b11));
        clearLanes();
        rrIf.stall = 1'b1;
        rrIf.flush_all = 1'b1;
        tick();
        checkOutput("flush_all_valid",   128'(rrIf.out_valid), 128'(0));
        checkOutput("flush_all_payload", 128'(rrIf.out_payload), 128'({48'h52, 48'h51}));
        rrIf.flush_req = 1'b0;
        rrIf.flush_all = 1'b0;
        rrIf.stall = 1'b0;
        tick();
        checkOutput("flush_all_rel_valid", 128'(rrIf.out_valid), 128'(0));

        // Back-to-back full-width stream of 8 ops.
        for (int c = 0; c < 10; c++) begin
            if (c < 8) begin
                for (int l = 0; l < IW; l++)
                    applyStimulus(l, 1'b1, c*2+l, 64+c*2+l, 100+l, c, 48'(c*16+l));
            end else begin
                clearLanes();
            end
            tick();
            if (c >= 1 && c <= 8) begin
                checkOutput("stream_valid",    128'(rrIf.out_valid), 128'(2'b11));
                checkOutput("stream_payload0", 128'(rrIf.out_payload[47:0]), 128'(48'((c-1)*16)));
                checkOutput("stream_payload1", 128'(rrIf.out_payload[95:48]), 128'(48'((c-1)*16+1)));
                checkOutput("stream_op_b1",    128'(rrIf.out_op_b[63:32]), 128'(rfVal(64+(c-1)*2+1)));
            end
        end
        checkOutput("stream_end_valid", 128'(rrIf.out_valid), 128'(0));

        // Asynchronous reset mid-stream with S and O valid.
        applyStimulus(0, 1'b1, 9, 9, 9, 30, 48'h99);
        applyStimulus(1, 1'b1, 8, 8, 8, 31, 48'h88);
        tick();
        tick();
        checkOutput("pre_rst_valid", 128'(rrIf.out_valid), 128'(2'b11));
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_valid",   128'(rrIf.out_valid),   128'(0));
        checkOutput("async_rst_op_a",    128'(rrIf.out_op_a),    128'(0));
        checkOutput("async_rst_op_b",    128'(rrIf.out_op_b),    128'(0));
        checkOutput("async_rst_payload", 128'(rrIf.out_payload), 128'(0));
        clearLanes();
        tick();
        rst = 1'b0;
        tick();
        checkOutput("post_rst_valid", 128'(rrIf.out_valid), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
